// File: rtl/branch_ex_stage_pkg.sv
// Shared definitions for the branch execute stage: funct3 branch encodings,
// the wrong-path kill state enum and the kill counter width.
package branch_ex_stage_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Wide enough for the largest legal KILL_CYCLES value (3).
  localparam int KCNT_W = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } kill_state_e;

endpackage

// File: rtl/branch_ex_stage_if.sv
// Upstream and downstream handshake plus payload of the branch execute stage.
// slave: the stage itself; master: whoever drives it (decode side and sink).
interface branch_ex_stage_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [31:0] i_imm;
  logic [2:0]  i_funct3;
  logic        i_is_branch;
  logic        i_is_jal;
  logic        i_is_jalr;

  logic        o_valid;
  logic        i_ready;
  logic        o_taken;
  logic        o_redirect;
  logic [31:0] o_target;
  logic [31:0] o_link;
  logic        o_illegal;
  logic        o_misalign;

  modport slave (
    input  i_valid, i_pc, i_rs1, i_rs2, i_imm, i_funct3,
           i_is_branch, i_is_jal, i_is_jalr, i_ready,
    output o_ready, o_valid, o_taken, o_redirect, o_target, o_link,
           o_illegal, o_misalign
  );

  modport master (
    output i_valid, i_pc, i_rs1, i_rs2, i_imm, i_funct3,
           i_is_branch, i_is_jal, i_is_jalr, i_ready,
    input  o_ready, o_valid, o_taken, o_redirect, o_target, o_link,
           o_illegal, o_misalign
  );
endinterface

// File: rtl/branch_ex_stage_cmp.sv
// Combinational operand comparator for the branch stage (branch_cmp) and the
// 32-bit signed set-less-than block it uses for the signed ordering.

// Signed set-less-than: lt_o = (a_i < b_i) in two's complement.
module slt32 (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic               lt_o
);
  assign lt_o = (a_i < b_i);
endmodule

module branch_cmp (
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        eq_o,
  output logic        lt_o,
  output logic        ltu_o
);
  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;

  assign rs1_s = $signed(rs1_i);
  assign rs2_s = $signed(rs2_i);

  slt32 u_slt (
    .a_i  (rs1_s),
    .b_i  (rs2_s),
    .lt_o (lt_o)
  );

  assign eq_o  = (rs1_i == rs2_i);
  assign ltu_o = (rs1_i < rs2_i);
endmodule

// File: rtl/branch_ex_stage.sv
// Branch execute stage: single registered stage that resolves branches and
// jumps, produces the redirect pulse/target and link value, and discards
// KILL_CYCLES wrong-path transfers after each redirect.
// Optional feature macro: BRANCH_MISALIGN_EN (flags taken targets with bit 1
// set as misaligned and suppresses their redirect).
module branch_ex_stage
  import branch_ex_stage_pkg::*;
#(
  parameter int KILL_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  branch_ex_stage_if.slave bus
);

  localparam bit                KILL_EN   = (KILL_CYCLES != 0);
  localparam logic [KCNT_W-1:0] KILL_INIT = KCNT_W'(KILL_CYCLES);

  // Branch condition selected by funct3; reserved encodings never take.
  function automatic logic branch_cond(input logic [2:0] f3, input logic eq,
                                       input logic lt, input logic ltu);
    case (f3)
      F3_BEQ:  branch_cond = eq;
      F3_BNE:  branch_cond = ~eq;
      F3_BLT:  branch_cond = lt;
      F3_BGE:  branch_cond = ~lt;
      F3_BLTU: branch_cond = ltu;
      F3_BGEU: branch_cond = ~ltu;
      default: branch_cond = 1'b0;
    endcase
  endfunction

  logic        cmp_eq, cmp_lt, cmp_ltu;
  logic        res_taken, res_illegal, res_misalign, res_redirect;
  logic [31:0] res_target, res_link, jalr_sum;

  logic        accept, load;

  kill_state_e       state_q, state_d;
  logic [KCNT_W-1:0] cnt_q, cnt_d;

  logic        valid_q, valid_d;
  logic        redirect_q, redirect_d;
  logic        taken_q, illegal_q, misalign_q;
  logic [31:0] target_q, link_q;

  branch_cmp u_cmp (
    .rs1_i (bus.i_rs1),
    .rs2_i (bus.i_rs2),
    .eq_o  (cmp_eq),
    .lt_o  (cmp_lt),
    .ltu_o (cmp_ltu)
  );

  assign accept = bus.i_valid & bus.o_ready;
  // Only transfers seen in RUN are real; KILL transfers are wrong-path.
  assign load   = accept & (state_q == ST_RUN) & ~i_flush;

  // Resolve the incoming instruction: taken, target, link and fault flags.
  always_comb begin
    jalr_sum    = bus.i_rs1 + bus.i_imm;
    res_illegal = bus.i_is_branch & (bus.i_funct3[2:1] == 2'b01);
    res_taken   = (bus.i_is_branch &
                   branch_cond(bus.i_funct3, cmp_eq, cmp_lt, cmp_ltu))
                | bus.i_is_jal | bus.i_is_jalr;
    res_target  = bus.i_is_jalr ? (jalr_sum & 32'hFFFF_FFFE)
                                : (bus.i_pc + bus.i_imm);
    res_link    = bus.i_pc + 32'd4;
`ifdef BRANCH_MISALIGN_EN
    res_misalign = res_taken & res_target[1];
`else
    res_misalign = 1'b0;
`endif
    res_redirect = res_taken & ~res_misalign;
  end

  // Kill FSM next state: arm on a loaded redirect, count down discarded transfers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load && res_redirect && KILL_EN) begin
            state_d = ST_KILL;
            cnt_d   = KILL_INIT;
          end
        end
        ST_KILL: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else if (accept) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == KCNT_W'(1)) state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Kill FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output valid and one-shot redirect next state.
  always_comb begin
    valid_d    = valid_q;
    redirect_d = 1'b0;
    if (valid_q && bus.i_ready) valid_d = 1'b0;
    if (load) begin
      valid_d    = 1'b1;
      redirect_d = res_redirect;
    end
    if (i_flush) begin
      valid_d    = 1'b0;
      redirect_d = 1'b0;
    end
  end

  // Stage register: control always updates, payload loads only on a real transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      target_q   <= '0;
      link_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
      if (load) begin
        taken_q    <= res_taken;
        illegal_q  <= res_illegal;
        misalign_q <= res_misalign;
        target_q   <= res_target;
        link_q     <= res_link;
      end
    end
  end

  assign bus.o_ready    = ~valid_q | bus.i_ready;
  assign bus.o_valid    = valid_q;
  assign bus.o_redirect = redirect_q;
  assign bus.o_taken    = taken_q;
  assign bus.o_illegal  = illegal_q;
  assign bus.o_misalign = misalign_q;
  assign bus.o_target   = target_q;
  assign bus.o_link     = link_q;

endmodule

// File: tb/tb_branch_ex_stage.sv
// Testbench for branch_ex_stage: directed table, multi-cycle corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_branch_ex_stage;

  localparam int KC = 2;
`ifdef BRANCH_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  branch_ex_stage_if bus ();

  branch_ex_stage #(.KILL_CYCLES(KC)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    bit          taken;
    bit          ill;
    bit          mis;
    bit          redir;
    logic [31:0] tgt;
    logic [31:0] link;
  } res_t;

  // Reference model state (architectural view of the stage)
  bit          m_valid, m_taken, m_redir, m_ill, m_mis, m_tgt_chk;
  logic [31:0] m_tgt, m_link;
  int          m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // cls: 0 none, 1 branch, 2 jal, 3 jalr
  function automatic res_t ref_exec(input logic [31:0] pc, rs1, rs2, imm,
                                    input logic [2:0] f3, input int cls);
    res_t r;
    logic [31:0] t;
    r = '0;
    if (cls == 1) begin
      case (f3)
        3'd0: r.taken = (rs1 == rs2);
        3'd1: r.taken = (rs1 != rs2);
        3'd4: r.taken = ($signed(rs1) < $signed(rs2));
        3'd5: r.taken = ($signed(rs1) >= $signed(rs2));
        3'd6: r.taken = (rs1 < rs2);
        3'd7: r.taken = (rs1 >= rs2);
        default: begin r.taken = 1'b0; r.ill = 1'b1; end
      endcase
    end else if (cls == 2 || cls == 3) begin
      r.taken = 1'b1;
    end
    if (cls == 3) begin
      t = rs1 + imm;
      t[0] = 1'b0;
    end else begin
      t = pc + imm;
    end
    r.tgt   = t;
    r.link  = pc + 32'd4;
    r.mis   = MIS_EN && r.taken && t[1];
    r.redir = r.taken && !r.mis;
    return r;
  endfunction

  task automatic set_in(input bit v, input logic [31:0] pc, rs1, rs2, imm,
                        input logic [2:0] f3, input int cls,
                        input bit rdy, input bit fl, input bit rs);
    bus.i_valid     = v;
    bus.i_pc        = pc;
    bus.i_rs1       = rs1;
    bus.i_rs2       = rs2;
    bus.i_imm       = imm;
    bus.i_funct3    = f3;
    bus.i_is_branch = (cls == 1);
    bus.i_is_jal    = (cls == 2);
    bus.i_is_jalr   = (cls == 3);
    bus.i_ready     = rdy;
    flush           = fl;
    rst             = rs;
  endtask

  // One clock: check ready, advance model and DUT, compare all outputs.
  task automatic do_cycle();
    bit   fire, c_rdy, c_fl, c_rst;
    int   cls;
    res_t r;
    #1;
    chk("o_ready", {31'd0, bus.o_ready}, {31'd0, (!m_valid || bus.i_ready)});
    cls   = bus.i_is_branch ? 1 : bus.i_is_jal ? 2 : bus.i_is_jalr ? 3 : 0;
    fire  = bus.i_valid && (!m_valid || bus.i_ready);
    r     = ref_exec(bus.i_pc, bus.i_rs1, bus.i_rs2, bus.i_imm, bus.i_funct3, cls);
    c_rdy = bus.i_ready;
    c_fl  = flush;
    c_rst = rst;
    @(posedge clk);
    #1;
    if (c_rst) begin
      m_valid = 0; m_taken = 0; m_redir = 0; m_ill = 0; m_mis = 0;
      m_tgt = '0; m_link = '0; m_tgt_chk = 1; m_drop = 0;
    end else if (c_fl) begin
      m_valid = 0; m_redir = 0; m_drop = 0;
    end else begin
      m_redir = 0;
      if (m_valid && c_rdy) m_valid = 0;
      if (fire) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          m_valid = 1; m_taken = r.taken; m_ill = r.ill; m_mis = r.mis;
          m_redir = r.redir; m_tgt = r.tgt; m_link = r.link;
          m_tgt_chk = (cls != 0);
          m_drop = r.redir ? KC : 0;
        end
      end
    end
    chk("o_valid",    {31'd0, bus.o_valid},    {31'd0, m_valid});
    chk("o_taken",    {31'd0, bus.o_taken},    {31'd0, m_taken});
    chk("o_redirect", {31'd0, bus.o_redirect}, {31'd0, m_redir});
    chk("o_illegal",  {31'd0, bus.o_illegal},  {31'd0, m_ill});
    chk("o_misalign", {31'd0, bus.o_misalign}, {31'd0, m_mis});
    chk("o_link",     bus.o_link, m_link);
    if (m_tgt_chk) chk("o_target", bus.o_target, m_tgt);
  endtask

  task automatic idle(input bit rdy, input bit fl);
    set_in(0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 0, rdy, fl, 0);
    do_cycle();
  endtask

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm;
    logic [2:0]  f3;
    int          cls;
    bit          taken, ill, mis_raw;
    logic [31:0] tgt, link;
    bit          tgt_chk;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{32'h100, 32'h5, 32'h5, 32'h8, 3'd0, 1, 1, 0, 0, 32'h108, 32'h104, 1};
    tbl[1]  = '{32'h100, 32'h5, 32'h6, 32'h8, 3'd0, 1, 0, 0, 0, 32'h108, 32'h104, 1};
    tbl[2]  = '{32'h100, 32'h5, 32'h6, 32'h8, 3'd1, 1, 1, 0, 0, 32'h108, 32'h104, 1};
    tbl[3]  = '{32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 3'd4, 1, 1, 0, 0, 32'h120, 32'h104, 1};
    tbl[4]  = '{32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 3'd6, 1, 0, 0, 0, 32'h120, 32'h104, 1};
    tbl[5]  = '{32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 3'd7, 1, 1, 0, 0, 32'h120, 32'h104, 1};
    tbl[6]  = '{32'h100, 32'h1, 32'hFFFFFFFF, 32'h20, 3'd5, 1, 1, 0, 0, 32'h120, 32'h104, 1};
    tbl[7]  = '{32'h100, 32'h5, 32'h5, 32'h8, 3'd2, 1, 0, 1, 0, 32'h108, 32'h104, 1};
    tbl[8]  = '{32'h200, 32'h0, 32'h0, 32'hFFFFFFF0, 3'd0, 2, 1, 0, 0, 32'h1F0, 32'h204, 1};
    tbl[9]  = '{32'h300, 32'h1003, 32'h0, 32'h0, 3'd0, 3, 1, 0, 1, 32'h1002, 32'h304, 1};
    tbl[10] = '{32'hFFFFFFFC, 32'h0, 32'h0, 32'h4, 3'd0, 0, 0, 0, 0, 32'h0, 32'h0, 0};
    tbl[11] = '{32'hFFFFFFF0, 32'h3, 32'h3, 32'h20, 3'd4, 1, 0, 0, 0, 32'h10, 32'hFFFFFFF4, 1};
    tbl[12] = '{32'h100, 32'h7, 32'h7, 32'h6, 3'd0, 1, 1, 0, 1, 32'h106, 32'h104, 1};
    tbl[13] = '{32'h100, 32'h2, 32'h3, 32'h4, 3'd7, 1, 0, 0, 0, 32'h104, 32'h104, 1};
    tbl[14] = '{32'h400, 32'hFFFFFFFF, 32'h0, 32'h3, 3'd0, 3, 1, 0, 1, 32'h2, 32'h404, 1};
    tbl[15] = '{32'h100, 32'h5, 32'h5, 32'h8, 3'd3, 1, 0, 1, 0, 32'h108, 32'h104, 1};

    m_drop = 0; m_tgt_chk = 1;
    // Reset state
    set_in(0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 1);
    do_cycle();
    do_cycle();
    chk("reset_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("reset_target", bus.o_target, 32'd0);

    // Directed table: one instruction, then a flush to clear any kill window
    for (int i = 0; i < 16; i++) begin
      set_in(1, tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].f3,
             tbl[i].cls, 1, 0, 0);
      do_cycle();
      chk($sformatf("tbl%0d_taken", i), {31'd0, bus.o_taken}, {31'd0, tbl[i].taken});
      chk($sformatf("tbl%0d_illegal", i), {31'd0, bus.o_illegal}, {31'd0, tbl[i].ill});
      chk($sformatf("tbl%0d_misalign", i), {31'd0, bus.o_misalign},
          {31'd0, (MIS_EN & tbl[i].mis_raw)});
      chk($sformatf("tbl%0d_redirect", i), {31'd0, bus.o_redirect},
          {31'd0, (tbl[i].taken & !(MIS_EN & tbl[i].mis_raw))});
      chk($sformatf("tbl%0d_link", i), bus.o_link, tbl[i].link);
      if (tbl[i].tgt_chk) chk($sformatf("tbl%0d_target", i), bus.o_target, tbl[i].tgt);
      idle(1, 1);
    end

    // Taken branch then three back-to-back inputs: first two are wrong-path
    set_in(1, 32'h100, 32'h5, 32'h5, 32'h8, 3'd0, 1, 1, 0, 0);
    do_cycle();
    chk("kill_redirect", {31'd0, bus.o_redirect}, 32'd1);
    set_in(1, 32'h500, 0, 0, 0, 3'd0, 0, 1, 0, 0);
    do_cycle();
    chk("kill_drop1", {31'd0, bus.o_valid}, 32'd0);
    set_in(1, 32'h504, 0, 0, 0, 3'd0, 0, 1, 0, 0);
    do_cycle();
    chk("kill_drop2", {31'd0, bus.o_valid}, 32'd0);
    set_in(1, 32'h508, 0, 0, 0, 3'd0, 0, 1, 0, 0);
    do_cycle();
    chk("kill_pass3_valid", {31'd0, bus.o_valid}, 32'd1);
    chk("kill_pass3_link", bus.o_link, 32'h50C);
    idle(1, 1);

    // Taken branch stalled by i_ready=0 for three cycles
    set_in(1, 32'h600, 32'h1, 32'h2, 32'h40, 3'd1, 1, 0, 0, 0);
    do_cycle();
    chk("stall_redirect0", {31'd0, bus.o_redirect}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle(0, 0);
      chk($sformatf("stall_redirect%0d", i + 1), {31'd0, bus.o_redirect}, 32'd0);
      chk($sformatf("stall_valid%0d", i + 1), {31'd0, bus.o_valid}, 32'd1);
      chk($sformatf("stall_target%0d", i + 1), bus.o_target, 32'h640);
    end
    idle(1, 1);

    // Flush together with a transfer: nothing loads, stage stays in RUN
    set_in(1, 32'h700, 32'h5, 32'h5, 32'h8, 3'd0, 1, 1, 1, 0);
    do_cycle();
    chk("flushxfer_valid", {31'd0, bus.o_valid}, 32'd0);
    set_in(1, 32'h710, 0, 0, 0, 3'd0, 0, 1, 0, 0);
    do_cycle();
    chk("flushxfer_next", {31'd0, bus.o_valid}, 32'd1);
    idle(1, 0);

    // Flush during an active kill window returns to RUN
    set_in(1, 32'h800, 32'h5, 32'h5, 32'h8, 3'd0, 1, 1, 0, 0);
    do_cycle();
    idle(1, 1);
    chk("flushkill_valid", {31'd0, bus.o_valid}, 32'd0);
    set_in(1, 32'h810, 0, 0, 0, 3'd0, 0, 1, 0, 0);
    do_cycle();
    chk("flushkill_next", {31'd0, bus.o_valid}, 32'd1);
    chk("flushkill_link", bus.o_link, 32'h814);
    idle(1, 0);

    // Reset in the middle of a kill window
    set_in(1, 32'h900, 32'h5, 32'h5, 32'h8, 3'd0, 1, 1, 0, 0);
    do_cycle();
    set_in(1, 32'h910, 32'h5, 32'h5, 32'h8, 3'd0, 1, 1, 1, 1);
    do_cycle();
    chk("rstkill_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rstkill_taken", {31'd0, bus.o_taken}, 32'd0);
    chk("rstkill_target", bus.o_target, 32'd0);
    chk("rstkill_link", bus.o_link, 32'd0);
    set_in(1, 32'h920, 0, 0, 0, 3'd0, 0, 1, 0, 0);
    do_cycle();
    chk("rstkill_next", {31'd0, bus.o_valid}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b, pc, imm;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = $urandom;
      set_in($urandom_range(0, 3) != 0, pc, a, b, imm, 3'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
